pb_sequencer: RTL and testbench
===============================

# pb_sequencer

Front-panel input controller for the 4-bit ALU board. Takes the four raw, bouncing pushbuttons, then synchronizes, debounces and edge-detects each one. Runs an operand-entry state machine that issues the one-cycle load enables for operand register A, operand register B and the output register, plus a clear pulse. It drives the datapath's control inputs and runs in the same clock domain as the operand registers.

## Interface
- DebounceCycles, 1000, consecutive stable cycles required before a button level is accepted (minimum 2; 1000 = 20 ms at 50 kHz)
- CntWidth, 10, debounce counter width; must satisfy 2^CntWidth >= DebounceCycles
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- pb  input  4  raw pushbuttons, active-high, asynchronous; pb[0]=load A, pb[1]=load B, pb[2]=execute, pb[3]=clear
- en_a  output  1  one-cycle pulse: operand register A loads
- en_b  output  1  one-cycle pulse: operand register B loads
- out_en  output  1  one-cycle pulse: output register captures ALU result
- clr  output  1  one-cycle pulse: clear operand/output registers
- state  output  2  current FSM state (debug LEDs)
- pb_level  output  4  debounced button levels

## Operation
- Per button: 2-FF synchronizer → debouncer → rising-edge detector (press = lvl & ~lvl_d). Releases generate nothing.
- Debouncer, per button:
  - s != lvl: if cnt == DebounceCycles-1, then lvl <= s and cnt <= 0; else cnt++.
  - s == lvl: cnt <= 0.
  - A glitch shorter than DebounceCycles cycles never changes lvl.
- FSM states: WAIT_A=2'd0, WAIT_B=2'd1, WAIT_OP=2'd2, SHOW=2'd3.
  - WAIT_A: press[0] → en_a, go WAIT_B.
  - WAIT_B: press[1] → en_b, go WAIT_OP.
  - WAIT_OP: press[2] → out_en, go SHOW.
  - SHOW: press[2] → out_en, stay (re-execute with new opcode). press[0] → en_a, go WAIT_B.
  - Any state: press[3] → clr, go WAIT_A. Clear has highest priority and suppresses all other presses in that cycle.
  - Presses not listed for the current state are ignored. They are not queued.
  - Simultaneous presses with no press[3]: only the press valid for the current state acts.
- At most one of en_a/en_b/out_en/clr is high in any cycle. All four are registered.
- Reset:
  - Values: sync FFs, lvl, lvl_d and counters = 0; state = WAIT_A; en_a = en_b = out_en = clr = 0; pb_level = 0.
  - Reset mid-debounce discards the pending count.
  - A button held through reset release is accepted as a press after debouncing, because lvl restarts at 0.

## Timing
- Raw pb rises and is stable from sampling edge 0:
  - synchronized value valid after edge 2;
  - lvl rises at edge 2+DebounceCycles;
  - press is high for the following cycle;
  - the FSM output pulse is high for exactly one cycle, after edge DebounceCycles+3.
- Release path has the same debounce latency; pb_level falls at edge 2+DebounceCycles after release.
- State updates on the same edge that asserts the output pulse.
- Holding a button asserts exactly one pulse, regardless of hold length.
- Minimum spacing between two accepted presses of one button is 2*DebounceCycles cycles.

## Test plan
All scenarios use DebounceCycles=4.
- Clean sequence: press/hold pb[0], then pb[1], then pb[2] (each held 10 cycles, released 10 cycles). Required: en_a, en_b and out_en each pulse once for 1 cycle, 7 cycles after the press; state steps 0→1→2→3.
- Bounce: pb[0] toggles 1,0,1,0 with 1–3-cycle widths, then stays high. Required: exactly one en_a pulse, 7 cycles after the final stable rise; a 3-cycle glitch alone gives no pulse and pb_level stays 0.
- Out-of-order press: in WAIT_A press pb[1] then pb[2]. Required: no output pulses, state stays 0. In SHOW, pb[2] again gives an out_en pulse with state 3; pb[0] gives en_a with state 1.
- Simultaneous press: in WAIT_OP, pb[2] and pb[3] rise on the same cycle. Required: only clr pulses, state → 0, no out_en.
- Async reset mid-debounce: hold pb[0], assert rst 2 cycles after the synchronizer output rises, release rst while pb[0] is still held. Required: all outputs 0 and state 0 during reset; one en_a pulse 7 cycles after rst deasserts.
- Long hold: hold pb[3] for 100 cycles. Required: exactly one clr pulse, and pb_level[3] = 1 from edge 6 until 6 cycles after release.

Source files
------------

// File: rtl/pb_sequencer.sv
// pb_sequencer: synchronize, debounce and edge-detect four pushbuttons and sequence ALU operand entry
module pb_sequencer #(
  parameter int DebounceCycles = 1000,
  parameter int CntWidth = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pb,
  output logic       en_a,
  output logic       en_b,
  output logic       out_en,
  output logic       clr,
  output logic [1:0] state,
  output logic [3:0] pb_level
);
  typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, WAIT_OP = 2'd2, SHOW = 2'd3} state_t;
  localparam logic [CntWidth-1:0] Last = CntWidth'(DebounceCycles - 1);
  logic [3:0] sync1, sync2, lvl, lvl_d, press;
  logic [CntWidth-1:0] cnt [4];
  state_t cur, nxt;
  logic nxt_a, nxt_b, nxt_out, nxt_clr;
  // two-flop synchronizer for the raw buttons and one-cycle delay of the debounced level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_d <= '0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
      lvl_d <= lvl;
    end
  // accept a new level only after it has differed from the current one for DebounceCycles cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lvl <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (sync2[i] != lvl[i]) begin
          if (cnt[i] == Last) begin
            lvl[i] <= sync2[i];
            cnt[i] <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
        end else cnt[i] <= '0;
    end
  assign press = lvl & ~lvl_d;
  // state register and registered one-cycle pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= WAIT_A;
      en_a <= 1'b0;
      en_b <= 1'b0;
      out_en <= 1'b0;
      clr <= 1'b0;
    end else begin
      cur <= nxt;
      en_a <= nxt_a;
      en_b <= nxt_b;
      out_en <= nxt_out;
      clr <= nxt_clr;
    end
  // clear overrides everything; otherwise only the press valid in the current state acts
  always_comb begin
    nxt = cur;
    nxt_a = 1'b0;
    nxt_b = 1'b0;
    nxt_out = 1'b0;
    nxt_clr = 1'b0;
    if (press[3]) begin
      nxt_clr = 1'b1;
      nxt = WAIT_A;
    end else
      case (cur)
        WAIT_A: if (press[0]) begin
          nxt_a = 1'b1;
          nxt = WAIT_B;
        end
        WAIT_B: if (press[1]) begin
          nxt_b = 1'b1;
          nxt = WAIT_OP;
        end
        WAIT_OP: if (press[2]) begin
          nxt_out = 1'b1;
          nxt = SHOW;
        end
        default: if (press[2]) nxt_out = 1'b1;
        else if (press[0]) begin
          nxt_a = 1'b1;
          nxt = WAIT_B;
        end
      endcase
  end
  assign state = cur;
  assign pb_level = lvl;
endmodule

// File: tb/tb_pb_sequencer.sv
// tb_pb_sequencer: scoreboard bench for pb_sequencer with DebounceCycles=4
module tb_pb_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] pb = '0;
  logic en_a, en_b, out_en, clr;
  logic [1:0] state;
  logic [3:0] pb_level;
  typedef struct {
    logic [3:0] code;
    int cyc;
    logic [1:0] st;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  localparam logic [3:0] PA = 4'b0001, PB = 4'b0010, PO = 4'b0100, PC = 4'b1000;

  pb_sequencer #(.DebounceCycles(4), .CntWidth(3)) dut (
    .clk(clk), .rst(rst), .pb(pb), .en_a(en_a), .en_b(en_b), .out_en(out_en),
    .clr(clr), .state(state), .pb_level(pb_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pb changes 1 time unit after edge cyc; the pulse follows 7 edges later
  task automatic expect_pulse(logic [3:0] code, logic [1:0] st);
    q.push_back('{code, cyc + 7, st});
  endtask

  task automatic tap(int b, bit exp, logic [3:0] code, logic [1:0] st);
    pb[b] = 1'b1;
    if (exp) expect_pulse(code, st);
    step(10);
    pb[b] = 1'b0;
    step(10);
  endtask

  // monitor: every cycle with a pulse consumes one scoreboard entry
  always @(negedge clk)
    if (!rst && ({clr, out_en, en_b, en_a} != 4'b0)) begin
      if (q.size() == 0) chk("unexpected_pulse", {clr, out_en, en_b, en_a}, 4'b0);
      else begin
        mon_e = q.pop_front();
        chk("pulse_code", {clr, out_en, en_b, en_a}, mon_e.code);
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("pulse_state", state, mon_e.st);
      end
    end

  initial begin
    step(3);
    chk("rst_pulses", {clr, out_en, en_b, en_a}, 4'b0);
    chk("rst_state", state, 2'd0);
    chk("rst_level", pb_level, 4'b0);
    rst = 1'b0;
    step(2);
    // clean sequence A, B, execute
    tap(0, 1, PA, 2'd1);
    tap(1, 1, PB, 2'd2);
    tap(2, 1, PO, 2'd3);
    chk("state_show", state, 2'd3);
    // re-execute in SHOW, then new operand A
    tap(2, 1, PO, 2'd3);
    tap(0, 1, PA, 2'd1);
    tap(3, 1, PC, 2'd0);
    // out-of-order presses in WAIT_A are ignored
    tap(1, 0, PB, 2'd0);
    tap(2, 0, PO, 2'd0);
    chk("state_ignored", state, 2'd0);
    // lone 3-cycle glitch never reaches pb_level
    pb[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("glitch_level", pb_level, 4'b0);
    end
    pb[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_level", pb_level, 4'b0);
    end
    // bouncing press gives one en_a after the final stable rise
    pb[0] = 1'b1;
    step(1);
    pb[0] = 1'b0;
    step(2);
    pb[0] = 1'b1;
    step(3);
    pb[0] = 1'b0;
    step(1);
    pb[0] = 1'b1;
    expect_pulse(PA, 2'd1);
    step(10);
    pb[0] = 1'b0;
    step(10);
    tap(1, 1, PB, 2'd2);
    // simultaneous execute and clear: clear wins
    pb = 4'b1100;
    expect_pulse(PC, 2'd0);
    step(10);
    pb = 4'b0000;
    step(10);
    chk("state_after_simul", state, 2'd0);
    // reset two cycles after the synchronizer output rises
    pb[0] = 1'b1;
    step(4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pulses", {clr, out_en, en_b, en_a}, 4'b0);
    chk("midrst_state", state, 2'd0);
    chk("midrst_level", pb_level, 4'b0);
    step(2);
    rst = 1'b0;
    expect_pulse(PA, 2'd1);
    step(10);
    pb[0] = 1'b0;
    step(10);
    // long hold of clear: one pulse, level tracks with debounce latency
    pb[3] = 1'b1;
    expect_pulse(PC, 2'd0);
    step(5);
    chk("hold_level_pre", pb_level[3], 1'b0);
    step(1);
    chk("hold_level_on", pb_level[3], 1'b1);
    step(94);
    pb[3] = 1'b0;
    step(5);
    chk("release_level_pre", pb_level[3], 1'b1);
    step(1);
    chk("release_level_off", pb_level[3], 1'b0);
    step(10);
    chk("queue_drained", q.size(), 0);
    chk("final_state", state, 2'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
